in_buf_reader: RTL and testbench
================================

IN_BUF_READER -- requirements
Module: in_buf_reader

Interface
REQ-001 SHALL have parameter IMG_W, default 480, meaning pixels per line.
REQ-002 SHALL have parameter IMG_H, default 272, meaning lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning buffer read-address width.
REQ-004 SHALL have parameter PIX_W, default 24, meaning pixel width (RGB888).
REQ-005 SHALL have port i_clk  input  1  read-side clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  input  1  frame-ready pulse, already synchronous to i_clk.
REQ-008 SHALL have port o_rd_en  output  1  buffer read enable.
REQ-009 SHALL have port o_rd_addr  output  ADDR_W  buffer read address, raster order.
REQ-010 SHALL have port i_rd_data  input  PIX_W  buffer read data, valid exactly one cycle after o_rd_en.
REQ-011 SHALL have port o_pix_valid  output  1  output pixel valid.
REQ-012 SHALL have port i_pix_ready  input  1  downstream accept.
REQ-013 SHALL have port o_pix_data  output  PIX_W  output pixel.
REQ-014 SHALL have ports o_sof, o_eol, o_eof  output  1 each  first pixel of frame / last pixel of line / last pixel of frame, qualified by o_pix_valid.
REQ-015 SHALL have port o_busy  output  1  high from frame start until o_done.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse, frame fully transferred.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on i_start, RUN->DRAIN after address IMG_W*IMG_H-1 issued, DRAIN->IDLE after the o_eof handshake.
REQ-018 SHALL issue addresses 0..IMG_W*IMG_H-1 once each, incrementing by 1 per asserted o_rd_en; o_rd_addr is don't-care when o_rd_en is low.
REQ-019 SHALL assert o_rd_en first on the edge after i_start is sampled, and o_pix_valid with pixel 0 exactly two cycles after that.
REQ-020 SHALL capture i_rd_data into a 2-entry output FIFO; SHALL assert o_rd_en only when FIFO occupancy plus in-flight reads minus the current pop is below 2, so no return is ever lost.
REQ-021 SHALL sustain one pixel per cycle while i_pix_ready is held high.
REQ-022 SHALL hold o_pix_data, o_sof, o_eol and o_eof stable while o_pix_valid && !i_pix_ready; SHALL never drop, duplicate or reorder pixels for any ready pattern.
REQ-023 SHALL derive o_sof/o_eol/o_eof from x/y counters carried with each FIFO entry (x wraps at IMG_W-1, y increments on wrap).
REQ-024 SHALL pulse o_done the cycle after the o_eof handshake, with o_busy falling in that same cycle.
REQ-025 SHALL ignore i_start while o_busy; i_start coinciding with o_done SHALL also be ignored.
REQ-026 SHALL assert no o_rd_en and no o_pix_valid in IDLE.

Reset
REQ-027 SHALL, on i_rst_n low at any time including mid-frame, immediately force state IDLE, empty the FIFO, discard in-flight reads, clear counters, and drive every output listed in REQ-008..REQ-016 (and o_missed_cnt) to 0.
REQ-028 SHALL, after reset release, issue no read until a new i_start.

Configuration
REQ-029 SHALL use macro IN_BUF_READER_MISSED_CNT_EN to compile in an output o_missed_cnt [7:0].
REQ-030 SHALL, with the macro defined, increment o_missed_cnt on every i_start ignored per REQ-025, saturating at 255, cleared only by reset.
REQ-031 SHALL, without the macro, omit o_missed_cnt entirely, with all other behaviour identical.

Verification (IMG_W=4, IMG_H=3)
REQ-032 SHALL test: i_start pulse, ready high -> addresses 0..11 on 12 consecutive cycles, 12 pixels in order, o_sof on pixel 0, o_eol on 3/7/11, o_eof on 11, o_done one cycle later.
REQ-033 SHALL test: ready toggled 1,0,0,1,... with randomized data -> output sequence equals memory contents 0..11, data held stable during stalls, no more than 2 reads outstanding plus buffered.
REQ-034 SHALL test: i_start reasserted at pixel 5 and again in the o_done cycle -> frame unaffected; with macro, o_missed_cnt=2.
REQ-035 SHALL test: i_rst_n low at pixel 6 -> all outputs 0 asynchronously; after release with no i_start, o_rd_en stays 0; a new i_start begins again at address 0 with o_sof.
REQ-036 SHALL test: 300 ignored starts with macro -> o_missed_cnt=255.

Source files
------------

// File: rtl/in_buf_reader.sv
// in_buf_reader: streams one frame out of a pixel buffer in raster order.
//
// On a frame-ready pulse the reader walks addresses 0..IMG_W*IMG_H-1 and
// issues reads to a buffer with one cycle of read latency. Returned pixels go
// into a 2-entry output FIFO that feeds a valid/ready pixel stream. The FIFO
// carries sof/eol/eof markers derived from per-entry x/y coordinates.
//
// Optional feature: define IN_BUF_READER_MISSED_CNT_EN to add o_missed_cnt,
// a saturating count of frame-ready pulses ignored because a frame was busy.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge) and asynchronous active-low reset
//   i_start            frame-ready pulse, synchronous to i_clk
//   o_rd_en, o_rd_addr buffer read request (address valid only with o_rd_en)
//   i_rd_data          buffer read data, valid the cycle after o_rd_en
//   o_pix_valid/i_pix_ready/o_pix_data  output pixel stream
//   o_sof, o_eol, o_eof  frame/line markers, qualified by o_pix_valid
//   o_busy             high from frame start until o_done
//   o_done             one-cycle pulse after the last pixel is accepted
//   o_missed_cnt       (optional) ignored-start counter, saturates at 255
module in_buf_reader #(
  parameter int unsigned IMG_W  = 480,
  parameter int unsigned IMG_H  = 272,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_done
`ifdef IN_BUF_READER_MISSED_CNT_EN
  ,
  output logic [7:0]        o_missed_cnt
`endif
);

  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);
  localparam logic [XW-1:0]     LastX    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     LastY    = YW'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pend_q;   // read issued last cycle; its data is on i_rd_data now
  logic              done_q;

  logic [PIX_W-1:0]  fifo_data_q [2];
  logic [XW-1:0]     fifo_x_q    [2];
  logic [YW-1:0]     fifo_y_q    [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [XW-1:0]     wx_q;     // coordinates tagged onto the next captured pixel
  logic [YW-1:0]     wy_q;

  logic              pop;
  logic              eof_hs;
  logic              start_ok;
  logic [2:0]        level;
  logic [XW-1:0]     head_x;
  logic [YW-1:0]     head_y;

  always_comb begin
    o_pix_valid = (count_q != 2'd0);
    pop         = o_pix_valid && i_pix_ready;
    head_x      = fifo_x_q[rd_ptr_q];
    head_y      = fifo_y_q[rd_ptr_q];

    // Slots already claimed once this edge settles: buffered + returning - leaving.
    // A new read may claim a slot only if one is left, so no return is dropped.
    level       = 3'(count_q) + 3'(pend_q) - 3'(pop);
    o_rd_en     = (state_q == StRun) && (level < 3'd2);
    o_rd_addr   = o_rd_en ? addr_q : '0;

    o_pix_data  = o_pix_valid ? fifo_data_q[rd_ptr_q] : '0;
    o_sof       = o_pix_valid && (head_x == '0) && (head_y == '0);
    o_eol       = o_pix_valid && (head_x == LastX);
    o_eof       = o_eol && (head_y == LastY);
    eof_hs      = pop && o_eof;

    o_busy      = (state_q != StIdle);
    o_done      = done_q;
    // The o_done cycle is already idle, but a start there is still ignored.
    start_ok    = i_start && (state_q == StIdle) && !done_q;
  end

  // Frame sequencing: address generation, read tracking, done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= o_rd_en;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q <= StRun;
            addr_q  <= '0;
          end
        end
        StRun: begin
          if (o_rd_en) begin
            if (addr_q == LastAddr) begin
              state_q <= StDrain;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          if (eof_hs) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO. Push is unconditional on a returning read: o_rd_en already
  // guaranteed room for it when it was issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_x_q[i]    <= '0;
        fifo_y_q[i]    <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      wx_q     <= '0;
      wy_q     <= '0;
    end else begin
      if (pend_q) begin
        fifo_data_q[wr_ptr_q] <= i_rd_data;
        fifo_x_q[wr_ptr_q]    <= wx_q;
        fifo_y_q[wr_ptr_q]    <= wy_q;
        wr_ptr_q              <= ~wr_ptr_q;
        // Coordinates wrap to 0,0 after the last pixel, ready for the next frame.
        if (wx_q == LastX) begin
          wx_q <= '0;
          wy_q <= (wy_q == LastY) ? '0 : wy_q + YW'(1);
        end else begin
          wx_q <= wx_q + XW'(1);
        end
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(pend_q) - 2'(pop);
    end
  end

`ifdef IN_BUF_READER_MISSED_CNT_EN
  logic [7:0] missed_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      missed_q <= 8'd0;
    end else if (i_start && (o_busy || done_q) && (missed_q != 8'hff)) begin
      missed_q <= missed_q + 8'd1;
    end
  end

  assign o_missed_cnt = missed_q;
`endif

endmodule

// File: tb/tb_in_buf_reader.sv
// Self-checking bench for in_buf_reader with a 4x3 frame. A negedge monitor
// records every read request and accepted pixel; each test task loads random
// buffer contents, queues the expected pixel stream, runs a frame and compares.
module tb_in_buf_reader;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned PW     = PIX_W + 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              ready = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              sof, eol, eof, busy, done;
`ifdef IN_BUF_READER_MISSED_CNT_EN
  logic [7:0]        missed_cnt;
`endif

  in_buf_reader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_rd_en    (rd_en),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_pix_valid(pix_valid),
    .i_pix_ready(ready),
    .o_pix_data (pix_data),
    .o_sof      (sof),
    .o_eol      (eol),
    .o_eof      (eof),
    .o_busy     (busy),
    .o_done     (done)
`ifdef IN_BUF_READER_MISSED_CNT_EN
    ,
    .o_missed_cnt(missed_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: synchronous read, data one cycle after the request.
  logic [PIX_W-1:0] mem [NPIX];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Monitor (sampled mid-cycle, well away from the rising edge).
  int                cyc        = 0;
  int                rd_total   = 0;
  int                outst      = 0;
  int                max_out    = 0;
  int                stall_viol = 0;
  int                done_seen  = 0;
  int                eof_cyc    = -1;
  int                done_cyc   = -1;
  int                start_cyc  = -1;
  logic              done_busy  = 1'b0;
  logic              stalled_prev = 1'b0;
  logic [PW-1:0]     held       = '0;
  logic [ADDR_W-1:0] rd_addr_q [$];
  int                rd_cyc_q  [$];
  logic [PW-1:0]     px_q      [$];
  int                px_cyc_q  [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_addr_q.push_back(rd_addr);
      rd_cyc_q.push_back(cyc);
      rd_total <= rd_total + 1;
    end
    if (pix_valid && ready) begin
      px_q.push_back({sof, eol, eof, pix_data});
      px_cyc_q.push_back(cyc);
      if (eof) eof_cyc <= cyc;
    end
    if (done) begin
      done_cyc  <= cyc;
      done_busy <= busy;
      done_seen <= done_seen + 1;
    end
    if (start) start_cyc <= cyc;
    if (!rst_n) begin
      outst <= 0;
    end else begin
      outst <= outst + int'(rd_en) - int'(pix_valid && ready);
      if (outst + int'(rd_en) - int'(pix_valid && ready) > max_out)
        max_out <= outst + int'(rd_en) - int'(pix_valid && ready);
    end
    if (stalled_prev && pix_valid && ({sof, eol, eof, pix_data} != held))
      stall_viol <= stall_viol + 1;
    stalled_prev <= rst_n && pix_valid && !ready;
    held         <= {sof, eol, eof, pix_data};
  end

  int            tests = 0;
  int            fails = 0;
  logic [PW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    exp_q.delete();
    for (int a = 0; a < int'(NPIX); a++) begin
      mem[a] = PIX_W'($urandom);
      exp_q.push_back({(a == 0), (a % int'(IMG_W) == int'(IMG_W) - 1), (a == int'(NPIX) - 1),
                       mem[a]});
    end
  endtask

  task automatic wait_done(input int bound);
    int  d0 = done_seen;
    bit  ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_seen != d0) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: o_done not seen within %0d cycles", bound);
    end
  endtask

  task automatic test_reset();
    int r0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rd_en, rd_addr, pix_valid, pix_data, sof, eol, eof, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd_en=%b addr=%h valid=%b data=%h busy=%b done=%b, want 0",
               rd_en, rd_addr, pix_valid, pix_data, busy, done);
    end
`ifdef IN_BUF_READER_MISSED_CNT_EN
    tests++;
    if (missed_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_missed: got %0d want 0", missed_cnt);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    r0 = rd_total;
    repeat (5) tick();
    tests++;
    if (rd_total != r0) begin
      fails++;
      $display("FAIL reset_no_read: got %0d reads want 0", rd_total - r0);
    end
  endtask

  task automatic test_basic();
    int            pb, rb, sc;
    logic [PW-1:0] e;
    load_frame();
    ready = 1'b1;
    pb = px_q.size();
    rb = rd_addr_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = start_cyc;
    wait_done(100);
    tests++;
    if (rd_addr_q.size() - rb != int'(NPIX)) begin
      fails++;
      $display("FAIL basic_read_count: got %0d want %0d", rd_addr_q.size() - rb, NPIX);
    end
    for (int i = 0; i < int'(NPIX); i++) begin
      tests++;
      if (rb + i >= rd_addr_q.size()) begin
        fails++;
        $display("FAIL basic_addr[%0d]: missing, want addr %0d", i, i);
      end else if (rd_addr_q[rb + i] !== ADDR_W'(i) || rd_cyc_q[rb + i] != sc + 1 + i) begin
        fails++;
        $display("FAIL basic_addr[%0d]: got addr %0d cyc %0d want addr %0d cyc %0d", i,
                 rd_addr_q[rb + i], rd_cyc_q[rb + i], i, sc + 1 + i);
      end
    end
    for (int i = 0; i < int'(NPIX); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (pb + i >= px_q.size()) begin
        fails++;
        $display("FAIL basic_pix[%0d]: missing, want %h", i, e);
      end else if (px_q[pb + i] !== e || px_cyc_q[pb + i] != sc + 3 + i) begin
        fails++;
        $display("FAIL basic_pix[%0d]: got %h cyc %0d want %h cyc %0d", i, px_q[pb + i],
                 px_cyc_q[pb + i], e, sc + 3 + i);
      end
    end
    tests++;
    if (done_cyc != eof_cyc + 1 || done_busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got done cyc %0d busy %b want cyc %0d busy 0", done_cyc,
               done_busy, eof_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            pb, d0;
    bit            ok = 1'b0;
    logic [PW-1:0] e;
    load_frame();
    pb = px_q.size();
    d0 = done_seen;
    for (int k = 0; k < 300; k++) begin
      start = (k == 0);
      ready = pat[k % 4];
      tick();
      if (done_seen != d0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_timeout: o_done not seen within 300 cycles");
    end
    tick();
    tests++;
    if (px_q.size() - pb != int'(NPIX)) begin
      fails++;
      $display("FAIL bp_count: got %0d pixels want %0d", px_q.size() - pb, NPIX);
    end
    for (int i = 0; i < int'(NPIX); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (pb + i >= px_q.size() || px_q[pb + i] !== e) begin
        fails++;
        $display("FAIL bp_pix[%0d]: got %h want %h", i,
                 (pb + i < px_q.size()) ? px_q[pb + i] : {PW{1'bx}}, e);
      end
    end
    tests++;
    if (stall_viol != 0) begin
      fails++;
      $display("FAIL bp_stall_hold: got %0d changes during stalls want 0", stall_viol);
    end
    tests++;
    if (max_out > 2) begin
      fails++;
      $display("FAIL bp_outstanding: got %0d want <= 2", max_out);
    end
  endtask

  task automatic test_ignored_start();
    int            pb, r0, d0;
    bit            s5 = 1'b0, hit = 1'b0, fired = 1'b0;
    logic [PW-1:0] e;
    load_frame();
    ready = 1'b1;
    pb = px_q.size();
    r0 = rd_total;
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      start = 1'b0;
      if (hit) begin
        start = 1'b1;
        fired = 1'b1;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL ign_done_cycle: got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        tick();
        start = 1'b0;
        break;
      end
      if (!s5 && px_q.size() - pb == 5) begin
        start = 1'b1;
        s5 = 1'b1;
      end
      hit = pix_valid && ready && eof;
    end
    start = 1'b0;
    tests++;
    if (!fired || !s5) begin
      fails++;
      $display("FAIL ign_timeout: got pixel5=%b eof=%b want both 1", s5, fired);
    end
    repeat (5) tick();
    tests++;
    if (rd_total - r0 != int'(NPIX) || done_seen - d0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_single_frame: got %0d reads %0d dones busy=%b want %0d 1 0",
               rd_total - r0, done_seen - d0, busy, NPIX);
    end
    for (int i = 0; i < int'(NPIX); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (pb + i >= px_q.size() || px_q[pb + i] !== e) begin
        fails++;
        $display("FAIL ign_pix[%0d]: got %h want %h", i,
                 (pb + i < px_q.size()) ? px_q[pb + i] : {PW{1'bx}}, e);
      end
    end
`ifdef IN_BUF_READER_MISSED_CNT_EN
    tests++;
    if (missed_cnt !== 8'd2) begin
      fails++;
      $display("FAIL ign_missed: got %0d want 2", missed_cnt);
    end
`endif
  endtask

  task automatic test_abort();
    int            pb, rb, r0, sc;
    bit            ok = 1'b0;
    logic [PW-1:0] e;
    load_frame();
    ready = 1'b1;
    pb = px_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (px_q.size() - pb >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL abort_reach_pix6: got %0d pixels want 6", px_q.size() - pb);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rd_en, rd_addr, pix_valid, pix_data, sof, eol, eof, busy, done} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got rd_en=%b valid=%b data=%h busy=%b want all 0",
               rd_en, pix_valid, pix_data, busy);
    end
`ifdef IN_BUF_READER_MISSED_CNT_EN
    tests++;
    if (missed_cnt !== 8'd0) begin
      fails++;
      $display("FAIL abort_missed: got %0d want 0", missed_cnt);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    r0 = rd_total;
    repeat (10) tick();
    tests++;
    if (rd_total != r0 || pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d reads valid=%b want 0 0", rd_total - r0, pix_valid);
    end
    load_frame();
    pb = px_q.size();
    rb = rd_addr_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = start_cyc;
    wait_done(100);
    tests++;
    if (rb >= rd_addr_q.size() || rd_addr_q[rb] !== '0 || rd_cyc_q[rb] != sc + 1) begin
      fails++;
      $display("FAIL abort_restart_addr: got first read addr %h want 0 at cyc %0d",
               (rb < rd_addr_q.size()) ? rd_addr_q[rb] : {ADDR_W{1'bx}}, sc + 1);
    end
    for (int i = 0; i < int'(NPIX); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (pb + i >= px_q.size() || px_q[pb + i] !== e) begin
        fails++;
        $display("FAIL abort_pix[%0d]: got %h want %h", i,
                 (pb + i < px_q.size()) ? px_q[pb + i] : {PW{1'bx}}, e);
      end
    end
  endtask

  task automatic test_many_starts();
    int            pb;
    logic [PW-1:0] e;
    load_frame();
    ready = 1'b0;
    pb = px_q.size();
    start = 1'b1;
    tick();
    repeat (300) tick();
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b1 || px_q.size() != pb) begin
      fails++;
      $display("FAIL many_stalled: got busy=%b pixels=%0d want busy=1 pixels=0", busy,
               px_q.size() - pb);
    end
`ifdef IN_BUF_READER_MISSED_CNT_EN
    tests++;
    if (missed_cnt !== 8'd255) begin
      fails++;
      $display("FAIL many_missed: got %0d want 255", missed_cnt);
    end
`endif
    ready = 1'b1;
    wait_done(100);
    for (int i = 0; i < int'(NPIX); i++) begin
      e = exp_q.pop_front();
      tests++;
      if (pb + i >= px_q.size() || px_q[pb + i] !== e) begin
        fails++;
        $display("FAIL many_pix[%0d]: got %h want %h", i,
                 (pb + i < px_q.size()) ? px_q[pb + i] : {PW{1'bx}}, e);
      end
    end
    tests++;
    if (max_out > 2) begin
      fails++;
      $display("FAIL many_outstanding: got %0d want <= 2", max_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_abort();
    test_many_starts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
